mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) owning the HI/LO registers.
//  Sits beside the EX stage and takes rs/rt operands from the ALU operand muxes.
//  Iterates 32 times on a single shared cla_32_bit adder (radix-2 shift-add / restoring divide).
//  The pipeline stalls on busy; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH  32  operand width; only 32 is supported
//  ITERS  32  iteration count; must equal WIDTH
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous, active-high reset
//  start         in   1   launch op with rs_val/rt_val; sampled only in IDLE
//  op            in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val        in   32  multiplicand / dividend
//  rt_val        in   32  multiplier / divisor
//  hi_we, lo_we  in   1   MTHI / MTLO write enables (IDLE only)
//  wdata         in   32  MTHI/MTLO data
//  busy          out  1   high from the cycle after start through the FIX state
//  done          out  1   one-cycle pulse when the new HI/LO become visible
//  div_by_zero   out  1   pulses with done when a DIV/DIVU had rt_val==0
//  hi, lo        out  32  HI/LO architectural registers
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset mid-operation aborts at once.
//  FSM: IDLE -start-> PREP -> ITER (cnt 0..31) -cnt==31-> FIX -> DONE -> IDLE (done=1 only in DONE).
//  Latency: start at edge k. PREP at k+1; iterations at edges k+2..k+33; FIX->DONE at k+34.
//   hi/lo are written at k+34; done and div_by_zero are high for the cycle after k+34.
//  PREP: latch op and rt==0 flag. Signed ops take |rs|, |rt| and latch the result signs:
//   product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
//  ITER mult: if multiplier LSB is set, {cout,acc} = acc + mcand (cla, Cin=0).
//   Then shift {cout,acc,mplier} right by 1.
//  ITER div: shift {rem,quo} left by 1. trial = rem - dvsr via cla (B=~dvsr, Cin=1).
//   If the shifted-out bit or Cout is 1: rem=trial, quo[0]=1.
//  FIX: negate the 64-bit product or quotient/remainder per the latched signs, then write hi/lo.
//   Mult: hi=product[63:32], lo=product[31:0]. Div: lo=quotient, hi=remainder.
//  Divide by zero (decided): lo=32'hFFFF_FFFF, hi=original rs_val, div_by_zero=1. Applies to DIV and DIVU.
//  DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0, no flag.
//  MTHI/MTLO: write at the edge when in IDLE; visible the next cycle.
//   If start is high in the same cycle, start wins and the MT write is dropped.
//   MT writes during busy or DONE are ignored; the stall logic must not issue them.
//  start while not IDLE: ignored, with no queuing. Operands are only sampled on the accepting edge.
//  hi/lo keep their old values until the FIX->DONE edge.
// STRUCTURE
//  mdu_pkg: typedef enum {IDLE,PREP,ITER,FIX,DONE} mdu_state_t; typedef enum logic[1:0] mdu_op_t;
//   localparam MDU_ITERS=32.
//  One cla_32_bit instance serves all ITER adds/subtracts; its operand muxes are selected by op class.
//  PREP/FIX negation uses plain two's-complement expressions. No further sub-modules.
// TESTING
//  1 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 1 cycle, 34 edges after start.
//  2 MULT -3*7 -> hi=FFFFFFFF, lo=FFFFFFEB. MULT 0*x -> 0/0.
//  3 DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002.
//  4 DIVU 5/0 -> lo=FFFFFFFF, hi=00000005, div_by_zero=1. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0, flag=0.
//  5 start and MTHI pulsed while busy -> ignored, result unchanged.
//    rst at iteration 10 -> next cycle busy=0, hi=lo=0; a new MULTU 6*7 gives lo=2A.
//  6 MTLO 1234 in IDLE -> lo=00001234 next cycle, hi unchanged.
//    MTHI and start in the same cycle -> op runs, MT write dropped.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} mdu_state_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  localparam int MDU_ITERS = 32;

endpackage

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups.
module cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [7:0]  grp_cin;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      logic [3:0] gg;
      logic [3:0] pp;
      logic       c0;
      logic       c1;
      logic       c2;
      logic       c3;

      assign gg = g[4*gi +: 4];
      assign pp = p[4*gi +: 4];
      assign c0 = grp_cin[gi];
      assign c1 = gg[0] | (pp[0] & c0);
      assign c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      assign c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
      assign sum[4*gi +: 4] = pp ^ {c3, c2, c1, c0};
      assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p[gi] = &pp;
    end
  endgenerate

  // Group carries resolved in one process so no net feeds back into itself.
  always_comb begin
    logic carry;
    carry   = cin;
    grp_cin = '0;
    for (int i = 0; i < 8; i++) begin
      grp_cin[i] = carry;
      carry      = grp_g[i] | (grp_p[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; one shared adder does
// shift-add multiply and restoring divide over 32 iterations.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERS);

  mdu_state_t         state_reg, state_next;
  mdu_op_t            op_reg;
  logic [WIDTH-1:0]   rs_reg, rt_reg;
  logic [WIDTH-1:0]   acc_reg, low_reg, dvsr_reg;
  logic [WIDTH-1:0]   acc_next, low_next;
  logic [CW-1:0]      cnt_reg;
  logic               neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   rs_mag, rt_mag, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] product, product_fix;
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   cla_a, cla_b, cla_sum;
  logic               cla_cout;

  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];

  // Divide works on the remainder pre-shifted by one; the subtract is A + ~B + 1.
  assign cla_a = is_div ? {acc_reg[WIDTH-2:0], low_reg[WIDTH-1]} : acc_reg;
  assign cla_b = is_div ? ~dvsr_reg : dvsr_reg;

  cla_32_bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (is_div),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt_reg == CW'(ITERS - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
    done        = (state_reg == DONE);
    div_by_zero = (state_reg == DONE) && dz_reg;
  end

  always_comb begin
    rs_mag = (is_signed && rs_reg[WIDTH-1]) ? -rs_reg : rs_reg;
    rt_mag = (is_signed && rt_reg[WIDTH-1]) ? -rt_reg : rt_reg;
  end

  // Divide: a set shifted-out bit means the partial remainder already exceeds the divisor.
  always_comb begin
    if (is_div) begin
      if (acc_reg[WIDTH-1] || cla_cout) begin
        acc_next = cla_sum;
        low_next = {low_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc_reg[WIDTH-2:0], low_reg[WIDTH-1]};
        low_next = {low_reg[WIDTH-2:0], 1'b0};
      end
    end else if (low_reg[0]) begin
      acc_next = {cla_cout, cla_sum[WIDTH-1:1]};
      low_next = {cla_sum[0], low_reg[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc_reg[WIDTH-1:1]};
      low_next = {acc_reg[0], low_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    product     = {acc_reg, low_reg};
    product_fix = neg_q_reg ? -product : product;
    if (!is_div) begin
      hi_fix = product_fix[2*WIDTH-1:WIDTH];
      lo_fix = product_fix[WIDTH-1:0];
    end else if (dz_reg) begin
      hi_fix = rs_reg;
      lo_fix = '1;
    end else begin
      hi_fix = neg_r_reg ? -acc_reg : acc_reg;
      lo_fix = neg_q_reg ? -low_reg : low_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= OP_MULT;
      rs_reg    <= '0;
      rt_reg    <= '0;
      acc_reg   <= '0;
      low_reg   <= '0;
      dvsr_reg  <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg <= mdu_op_t'(op);
            rs_reg <= rs_val;
            rt_reg <= rt_val;
          end else begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
          end
        end
        PREP: begin
          acc_reg   <= '0;
          low_reg   <= is_div ? rs_mag : rt_mag;
          dvsr_reg  <= is_div ? rt_mag : rs_mag;
          cnt_reg   <= '0;
          neg_q_reg <= is_signed && (rs_reg[WIDTH-1] ^ rt_reg[WIDTH-1]);
          neg_r_reg <= is_signed && rs_reg[WIDTH-1];
          dz_reg    <= is_div && (rt_reg == '0);
        end
        ITER: begin
          acc_reg <= acc_next;
          low_reg <= low_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          hi_reg <= hi_fix;
          lo_reg <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit / signed 32-bit arithmetic on the architectural rules.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    case (o)
      2'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        h = sp[63:32];
        l = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32];
        l = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (o == 2'd3) begin
          l = a / b;
          h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
    endcase
  endfunction

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got=no done expected=done within 100 cycles", name);
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz, output int lat);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done("op", lat);
    h = hi; l = lo; dz = div_by_zero;
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h dz=%0b lat=%0d", o, a, b, h, l, dz, lat);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] h, l, eh, el, a, b, old_hi;
    logic        dz, edz;
    logic [1:0]  o;
    int          lat, r;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[5] = '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    rst = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, dz, lat);
      check($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
    end

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r == 1) b = 32'($urandom_range(1, 15));
      else if (r == 2) b = 32'hFFFF_FFFF;
      else b = $urandom;
      if (r == 3) a = 32'h8000_0000;
      ref_model(o, a, b, eh, el, edz);
      run_op(o, a, b, h, l, dz, lat);
      check($sformatf("rand%0d_hi", i), 64'(h), 64'(eh));
      check($sformatf("rand%0d_lo", i), 64'(l), 64'(el));
      check($sformatf("rand%0d_dz", i), 64'(dz), 64'(edz));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
    end

    // MTLO in IDLE: visible next cycle, HI untouched.
    old_hi = hi;
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    $display("mtlo wdata=00001234 -> hi=%h lo=%h", hi, lo);
    check("mtlo_lo", 64'(lo), 64'h0000_1234);
    check("mtlo_hi", 64'(hi), 64'(old_hi));

    // MTHI together with start: the operation wins, the write is dropped.
    old_hi = hi;
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    start = 1'b1; op = 2'd1; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("mthi_start_dropped", 64'(hi), 64'(old_hi));
    wait_done("mthi_start", lat);
    $display("mthi+start multu 2*3 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("mthi_start_hi", 64'(hi), 64'd0);
    check("mthi_start_lo", 64'(lo), 64'd6);
    @(posedge clk); #1;

    // start and MTHI while busy are ignored; HI/LO hold until the result lands.
    old_hi = 32'h0000_7777;
    hi_we = 1'b1; wdata = old_hi;
    @(posedge clk); #1;
    hi_we = 1'b0;
    start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd0; rs_val = 32'hFFFF; rt_val = 32'hFFFF;
    hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_hold_hi", 64'(hi), 64'(old_hi));
    wait_done("busy_ignore", lat);
    $display("multu 3*5 with busy start/mthi -> hi=%h lo=%h", hi, lo);
    check("busy_ignore_hi", 64'(hi), 64'd0);
    check("busy_ignore_lo", 64'(lo), 64'd15);
    repeat (2) @(posedge clk);
    #1;
    check("busy_no_queue", 64'(busy), 64'd0);

    // Reset during iteration 10 aborts immediately.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_5555;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", 64'(hi), 64'h0000_5555);
    start = 1'b1; op = 2'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-op -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    check("midrst_idle", 64'(busy), 64'd0);
    run_op(2'd1, 32'd6, 32'd7, h, l, dz, lat);
    check("after_rst_lo", 64'(l), 64'h2A);
    check("after_rst_hi", 64'(h), 64'd0);
    check("after_rst_latency", 64'(lat), 64'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
